boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width of the target RAMs.
REQ-002 Parameter MAGIC, default 8'hA5, segment start byte.
REQ-003 clk_in  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  byte stream from host link.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts byte; transfer = in_valid && in_ready at rising edge.
REQ-008 mem_we  output  1  one-cycle word write strobe.
REQ-009 mem_sel  output  1  0 = instruction RAM, 1 = data RAM.
REQ-010 mem_addr  output  ADDR_W  word address of current write.
REQ-011 mem_wdata  output  32  write word.
REQ-012 cpu_hold  output  1  holds the CPU in reset while high.
REQ-013 done  output  1  high once the final segment is loaded and verified; sticky.
REQ-014 err  output  1  checksum failure flag; sticky until the next MAGIC is accepted.

Function
REQ-015 Segment format: MAGIC, FLAGS, LEN_HI, LEN_LO, LEN words of 4 bytes each (big-endian), CSUM.
REQ-016 FLAGS: bit0 = mem_sel for the segment; bit7 = last segment; other bits are ignored.
REQ-017 FSM states: IDLE, FLAGS, LEN_HI, LEN_LO, DATA, CSUM, DONE.
REQ-018 IDLE: accepted byte == MAGIC -> FLAGS and clear err; any other byte is discarded and the FSM stays in IDLE.
REQ-019 FLAGS -> LEN_HI -> LEN_LO, one accepted byte each; mem_addr resets to 0 on leaving FLAGS.
REQ-020 LEN_LO: LEN == 0 -> CSUM; otherwise -> DATA.
REQ-021 DATA: bytes assemble MSB first; acceptance of a word's 4th byte at edge k drives mem_we=1 for exactly the cycle after edge k, with mem_addr, mem_sel and mem_wdata stable for that cycle.
REQ-022 mem_addr increments by 1 after each write and wraps modulo 2^ADDR_W.
REQ-023 After write number LEN, the FSM moves to CSUM.
REQ-024 Running checksum = XOR of FLAGS, LEN_HI, LEN_LO and all data bytes; MAGIC and CSUM are excluded.
REQ-025 CSUM match and FLAGS bit7=1 -> DONE; done=1 and cpu_hold=0 on the next cycle.
REQ-026 CSUM match and bit7=0 -> IDLE.
REQ-027 CSUM mismatch -> err=1, IDLE; cpu_hold stays 1; words already written are not rolled back.
REQ-028 in_ready = 1 in every state except DONE, where it is 0 and all input is ignored until reset.
REQ-029 in_valid=0 stalls the FSM with no state or output change; mem_we still completes its one pulse.
REQ-030 Back-to-back bytes on consecutive cycles are accepted at full rate; 1 byte/cycle, no bubbles.
REQ-031 mem_we is 0 in every cycle other than those defined in REQ-021.

Reset
REQ-032 Asserting reset at any time (including mid-word or mid-segment) forces state=IDLE, in_ready=1, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, checksum=0, and clears the byte counter.
REQ-033 A partially assembled word is discarded on reset; no write is issued.

Structure
REQ-034 Shared package seme4_boot_pkg holds the FSM state encoding, default MAGIC, FLAGS bit positions (SEL=0, LAST=7) and segment header length.
REQ-035 One sub-module, boot_word_asm: byte-to-word shift register plus 2-bit byte counter producing a word_valid pulse; the FSM, address, checksum and hold logic stay in boot_loader.

Verification
REQ-036 Stream A5 80 00 01 DE AD BE EF CSUM=80^00^01^DE^AD^BE^EF -> one mem_we, sel=0, addr=0, wdata=DEADBEEF; done=1, cpu_hold=0.
REQ-037 Segment with FLAGS 01, LEN=3 (words 1,2,3), then segment with FLAGS 80, LEN=2 -> dram addresses 0..2 then iram addresses 0..1 written in order; done only after the second CSUM.
REQ-038 Bad CSUM (correct value XOR 01) -> err=1, done=0, cpu_hold=1; the next A5 clears err and a valid segment completes normally.
REQ-039 Garbage 00 FF 12 before A5 -> ignored with no writes; LEN=0 with CSUM=FLAGS -> no writes, segment completes.
REQ-040 Reset asserted after the 2nd byte of a word -> no mem_we, all outputs at reset values; a full stream replayed afterwards loads correctly.
REQ-041 Random in_valid gaps in REQ-036 stream -> identical writes; with ADDR_W=2 and LEN=5, the 5th write lands at addr 0 (wrap).

Source files
------------

// File: rtl/seme4_boot_pkg.sv
// Shared definitions for the segment boot loader: FSM encoding, default
// start byte and FLAGS bit positions.
package seme4_boot_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FLAGS, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM, ST_DONE
  } state_e;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int         FLAG_SEL  = 0;
  localparam int         FLAG_LAST = 7;
  localparam int         HDR_LEN   = 4;  // MAGIC, FLAGS, LEN_HI, LEN_LO
endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler: collects 4 bytes MSB first and pulses word_valid
// combinationally alongside the 4th byte so the caller can register the write.
module boot_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (byte_en) begin
      sh_d  = {sh_q[15:0], byte_in};
      cnt_d = cnt_q + 2'd1;
    end
  end

  assign word       = {sh_q, byte_in};
  assign word_valid = byte_en && (cnt_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/boot_loader.sv
// Host-link boot loader: parses MAGIC/FLAGS/LEN/data/CSUM segments, writes
// words into instruction or data RAM and releases the CPU after the last one.
module boot_loader
  import seme4_boot_pkg::*;
#(
  parameter int         ADDR_W = 11,
  parameter logic [7:0] MAGIC  = MAGIC_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  state_e            state_q, state_d;
  logic              we_q, we_d, sel_q, sel_d, last_q, last_d;
  logic              hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        csum_q, csum_d;
  logic [15:0]       rem_q, rem_d;
  logic              acc, byte_en, word_valid;
  logic [31:0]       word;

  assign in_ready = (state_q != ST_DONE);
  assign acc      = in_valid && in_ready;
  assign byte_en  = acc && (state_q == ST_DATA);

  boot_word_asm u_asm (
    .clk(clk_in), .rst(reset), .byte_en(byte_en), .byte_in(in_data),
    .word(word), .word_valid(word_valid)
  );

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    csum_d  = csum_q;
    rem_d   = rem_q;
    // Advance the address once the write cycle has been presented.
    if (we_q) addr_d = addr_q + 1'b1;
    if (acc) begin
      unique case (state_q)
        ST_IDLE: if (in_data == MAGIC) begin
          state_d = ST_FLAGS;
          err_d   = 1'b0;
          csum_d  = '0;
        end
        ST_FLAGS: begin
          sel_d   = in_data[FLAG_SEL];
          last_d  = in_data[FLAG_LAST];
          csum_d  = csum_q ^ in_data;
          addr_d  = '0;
          state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          rem_d   = {in_data, 8'h00};
          csum_d  = csum_q ^ in_data;
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          rem_d   = {rem_q[15:8], in_data};
          csum_d  = csum_q ^ in_data;
          state_d = ({rem_q[15:8], in_data} == 16'd0) ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          csum_d = csum_q ^ in_data;
          if (word_valid) begin
            we_d    = 1'b1;
            wdata_d = word;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (in_data == csum_q) begin
            if (last_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      csum_q  <= csum_d;
      rem_q   <= rem_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: segments are built as byte lists tagged with the
// write/status effect each byte must have, and two DUTs (ADDR_W 11 and 2) share the stream.
module tb_boot_loader;
  localparam int K_NONE = 0, K_MAG = 1, K_OKL = 2, K_OKM = 3, K_BAD = 4;

  typedef struct {
    logic [7:0]  b;
    int          kind;
    bit          wend;
    bit          sel;
    int          addr;
    logic [31:0] w;
  } tx_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;

  logic rdy0, we0, sel0, hold0, done0, err0;
  logic [10:0] addr0;
  logic [31:0] wd0;
  logic rdy1, we1, sel1, hold1, done1, err1;
  logic [1:0] addr1;
  logic [31:0] wd1;

  boot_loader u0 (
    .clk_in(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .mem_we(we0), .mem_sel(sel0), .mem_addr(addr0),
    .mem_wdata(wd0), .cpu_hold(hold0), .done(done0), .err(err0)
  );
  boot_loader #(.ADDR_W(2)) u1 (
    .clk_in(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .mem_we(we1), .mem_sel(sel1), .mem_addr(addr1),
    .mem_wdata(wd1), .cpu_hold(hold1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  tx_t txq[$];
  bit  pend = 0;
  tx_t pw;
  bit  exp_done = 0;
  bit  exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("we0", 32'(we0), 32'(pend));
    chk("we1", 32'(we1), 32'(pend));
    if (pend) begin
      chk("sel0", 32'(sel0), 32'(pw.sel));
      chk("sel1", 32'(sel1), 32'(pw.sel));
      chk("addr0", 32'(addr0), 32'(pw.addr % 2048));
      chk("addr1", 32'(addr1), 32'(pw.addr % 4));
      chk("wdata0", wd0, pw.w);
      chk("wdata1", wd1, pw.w);
    end
    chk("done0", 32'(done0), 32'(exp_done));
    chk("done1", 32'(done1), 32'(exp_done));
    chk("err0", 32'(err0), 32'(exp_err));
    chk("err1", 32'(err1), 32'(exp_err));
    chk("hold0", 32'(hold0), 32'(!exp_done));
    chk("hold1", 32'(hold1), 32'(!exp_done));
    chk("ready0", 32'(rdy0), 32'(!exp_done));
    chk("ready1", 32'(rdy1), 32'(!exp_done));
  endtask

  function automatic void push(input logic [7:0] b, input int kind, input bit wend,
                               input bit sel, input int addr, input logic [31:0] w);
    tx_t t;
    t.b = b; t.kind = kind; t.wend = wend; t.sel = sel; t.addr = addr; t.w = w;
    txq.push_back(t);
  endfunction

  // One segment; cx != 0 corrupts the checksum byte.
  function automatic void build_seg(input logic [7:0] flags, input int len, input logic [7:0] cx,
                                    input bit rnd, input logic [31:0] base);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] l16;
    int kind;
    l16 = 16'(len);
    push(8'hA5, K_MAG, 0, 0, 0, 0);
    push(flags, K_NONE, 0, 0, 0, 0);
    push(l16[15:8], K_NONE, 0, 0, 0, 0);
    push(l16[7:0], K_NONE, 0, 0, 0, 0);
    cs = flags ^ l16[15:8] ^ l16[7:0];
    for (int i = 0; i < len; i++) begin
      w = rnd ? $urandom : base + 32'(i);
      for (int j = 0; j < 4; j++) begin
        logic [7:0] b;
        b = w[31 - 8*j -: 8];
        cs ^= b;
        push(b, K_NONE, j == 3, flags[0], i, w);
      end
    end
    if (cx != 8'h00) kind = K_BAD;
    else kind = flags[7] ? K_OKL : K_OKM;
    push(cs ^ cx, kind, 0, 0, 0, 0);
  endfunction

  // Feed up to nmax bytes (-1 = whole queue) with gap% idle cycles.
  task automatic run(input int gap, input int nmax);
    int n = 0;
    tx_t t;
    while (txq.size() > 0 && (nmax < 0 || n < nmax)) begin
      @(negedge clk);
      check_outputs();
      pend = 0;
      if ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
      end else begin
        t = txq.pop_front();
        n++;
        in_valid = 1'b1;
        in_data  = t.b;
        if (!exp_done) begin
          if (t.kind == K_MAG) exp_err = 0;
          if (t.kind == K_OKL) exp_done = 1;
          if (t.kind == K_BAD) exp_err = 1;
          if (t.wend) begin pend = 1; pw = t; end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
      pend = 0;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    in_valid = 1'b0;
    pend = 0;
    exp_done = 0;
    exp_err = 0;
    txq.delete();
    @(negedge clk);
    check_outputs();
    chk("rst_addr0", 32'(addr0), 0);
    chk("rst_addr1", 32'(addr1), 0);
    chk("rst_sel0", 32'(sel0), 0);
    chk("rst_wdata0", wd0, 0);
    chk("rst_wdata1", wd1, 0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single-word last segment, then input must be ignored once done.
    build_seg(8'h80, 1, 8'h00, 0, 32'hDEADBEEF);
    run(0, -1);
    idle(3);
    build_seg(8'h80, 2, 8'h00, 1, 0);
    run(0, -1);
    idle(3);

    // Two segments: dram 0..2 then iram 0..1.
    do_reset();
    build_seg(8'h01, 3, 8'h00, 0, 32'd1);
    build_seg(8'h80, 2, 8'h00, 1, 0);
    run(0, -1);
    idle(3);

    // Bad checksum, then recovery.
    do_reset();
    build_seg(8'h80, 2, 8'h01, 1, 0);
    run(20, -1);
    idle(4);
    build_seg(8'h80, 1, 8'h00, 1, 0);
    run(20, -1);
    idle(3);

    // Garbage before MAGIC; empty segment.
    do_reset();
    push(8'h00, K_NONE, 0, 0, 0, 0);
    push(8'hFF, K_NONE, 0, 0, 0, 0);
    push(8'h12, K_NONE, 0, 0, 0, 0);
    build_seg(8'h80, 0, 8'h00, 1, 0);
    run(0, -1);
    idle(3);

    // Reset after the 2nd byte of the first word, then full replay.
    do_reset();
    build_seg(8'h80, 2, 8'h00, 1, 0);
    run(0, 6);
    do_reset();
    build_seg(8'h80, 2, 8'h00, 1, 0);
    run(0, -1);
    idle(3);

    // Gapped stream; address wrap on the narrow instance.
    do_reset();
    build_seg(8'h80, 1, 8'h00, 0, 32'hDEADBEEF);
    run(50, -1);
    idle(3);
    do_reset();
    build_seg(8'h81, 5, 8'h00, 1, 0);
    run(30, -1);
    idle(3);

    // Long segment exercising LEN_HI, then a mix ending in a last one.
    do_reset();
    build_seg(8'h01, 260, 8'h00, 1, 0);
    build_seg(8'h7E, 3, 8'h00, 1, 0);
    build_seg(8'hFF, 7, 8'h00, 1, 0);
    run(25, -1);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
